// File: rtl/uart_pkg.sv
// Shared UART constants and the RX FIFO status record used by the register map.
package uart_pkg;

  localparam int unsigned UART_DATA_WIDTH     = 8;
  localparam int unsigned UART_FIFO_DEPTH     = 16;
  localparam int unsigned UART_TIMEOUT_CYCLES = 17360;

  typedef struct packed {
    logic empty;
    logic full;
    logic overflow;
    logic level_irq;
    logic timeout_irq;
  } uart_fifo_status_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port, one async read port.
module uart_fifo_mem #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DATA_WIDTH = 8,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic [AW-1:0]         wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]         rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FWFT FIFO with status flags and fill-level interrupt.
// Define UART_RX_FIFO_TIMEOUT_EN to build the idle-timeout interrupt counter.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH          = UART_FIFO_DEPTH,
  parameter int unsigned DATA_WIDTH     = UART_DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = UART_TIMEOUT_CYCLES,
  localparam int unsigned CW            = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid_i,
  input  logic [DATA_WIDTH-1:0] rx_data_i,
  input  logic                  flush_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [CW-1:0]         count_o,
  input  logic [CW-1:0]         threshold_i,
  output logic                  level_irq_o,
  output logic                  overflow_o,
  input  logic                  clr_overflow_i,
  output logic                  timeout_irq_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("uart_rx_fifo: DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 2");
  end

  logic              rx_valid_q, rx_valid_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              level_irq_q, level_irq_d;
  logic              push, pop, wr_en, empty, full, timeout_irq;
  logic [DATA_WIDTH-1:0] head_data;
  uart_fifo_status_t status;

  always_comb begin
    empty       = (count_q == '0);
    full        = (count_q == CW'(DEPTH));
    push        = rx_valid_i & ~rx_valid_q;
    pop         = rd_en_i & ~empty;
    // A full FIFO still accepts a byte when a pop frees the head slot the same cycle.
    wr_en       = push & ~flush_i & (~full | pop);
    rx_valid_d  = rx_valid_i;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    if (clr_overflow_i) overflow_d = 1'b0;
    if (push && full && !pop && !flush_i) overflow_d = 1'b1;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_en, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
    level_irq_d = (threshold_i != '0) && (count_q >= threshold_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_valid_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      level_irq_q <= 1'b0;
    end else begin
      rx_valid_q  <= rx_valid_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      level_irq_q <= level_irq_d;
    end
  end

  uart_fifo_mem #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (rx_data_i),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (head_data)
  );

`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

  logic [TW-1:0] tmr_q, tmr_d;
  logic          timeout_irq_q, timeout_irq_d;

  always_comb begin
    tmr_d         = tmr_q;
    timeout_irq_d = timeout_irq_q;
    if (push || pop || flush_i || empty) tmr_d = TW'(TIMEOUT_CYCLES - 1);
    else if (tmr_q != '0)                tmr_d = tmr_q - 1'b1;
    if (push || pop || flush_i)          timeout_irq_d = 1'b0;
    else if (tmr_q == '0 && !empty)      timeout_irq_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr_q         <= TW'(TIMEOUT_CYCLES - 1);
      timeout_irq_q <= 1'b0;
    end else begin
      tmr_q         <= tmr_d;
      timeout_irq_q <= timeout_irq_d;
    end
  end

  assign timeout_irq = timeout_irq_q;
`else
  assign timeout_irq = 1'b0;
`endif

  always_comb begin
    status.empty       = empty;
    status.full        = full;
    status.overflow    = overflow_q;
    status.level_irq   = level_irq_q;
    status.timeout_irq = timeout_irq;
  end

  assign rd_data_o     = empty ? '0 : head_data;
  assign count_o       = count_q;
  assign empty_o       = status.empty;
  assign full_o        = status.full;
  assign overflow_o    = status.overflow;
  assign level_irq_o   = status.level_irq;
  assign timeout_irq_o = status.timeout_irq;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: expected bytes queued at push, checked by a pop monitor.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int DW    = 8;
  localparam int CW    = 5;
  localparam int TMO   = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_valid_i = 1'b0;
  logic [DW-1:0] rx_data_i = '0;
  logic          flush_i = 1'b0;
  logic          rd_en_i = 1'b0;
  logic [DW-1:0] rd_data_o;
  logic          empty_o, full_o;
  logic [CW-1:0] count_o;
  logic [CW-1:0] threshold_i = '0;
  logic          level_irq_o, overflow_o;
  logic          clr_overflow_i = 1'b0;
  logic          timeout_irq_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];

  uart_rx_fifo #(
    .DEPTH          (DEPTH),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_valid_i     (rx_valid_i),
    .rx_data_i      (rx_data_i),
    .flush_i        (flush_i),
    .rd_en_i        (rd_en_i),
    .rd_data_o      (rd_data_o),
    .empty_o        (empty_o),
    .full_o         (full_o),
    .count_o        (count_o),
    .threshold_i    (threshold_i),
    .level_irq_o    (level_irq_o),
    .overflow_o     (overflow_o),
    .clr_overflow_i (clr_overflow_i),
    .timeout_irq_o  (timeout_irq_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a pop happens at the next rising edge, so the head is compared mid-cycle.
  always @(negedge clk) begin
    if (!rst && rd_en_i && !empty_o) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pop_unexpected: got 0x%0h expected no data", rd_data_o);
      end else begin
        check("pop_data", rd_data_o, exp_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [DW-1:0] b, input int hold, input bit stored);
    @(posedge clk); #1;
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    if (stored) exp_q.push_back(b);
    repeat (hold) @(posedge clk);
    #1;
    rx_valid_i = 1'b0;
  endtask

  task automatic pop_n(input int n);
    @(posedge clk); #1;
    rd_en_i = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rd_en_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_count"},   count_o, 0);
    check({tag, "_empty"},   empty_o, 1);
    check({tag, "_full"},    full_o, 0);
    check({tag, "_rd_data"}, rd_data_o, 0);
    check({tag, "_ovf"},     overflow_o, 0);
    check({tag, "_level"},   level_irq_o, 0);
    check({tag, "_tmo"},     timeout_irq_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1;
    check_reset_outputs("rst0");
    tick(3);
    rst = 1'b0;
    tick(2);
    check_reset_outputs("post_rst");

    // 1: long valid pulse yields exactly one entry
    push_byte(8'hA5, 5, 1'b1);
    tick(2);
    check("t1_count", count_o, 1);
    check("t1_data", rd_data_o, 8'hA5);
    check("t1_empty", empty_o, 0);
    pop_n(1);
    tick(1);
    check("t1_empty_after", empty_o, 1);

    // 2: fill, overflow, set-wins clear, drain in order
    for (int i = 0; i < DEPTH; i++) push_byte(DW'(i), 1, 1'b1);
    check("t2_full", full_o, 1);
    check("t2_count16", count_o, 16);
    check("t2_ovf_before", overflow_o, 0);
    push_byte(8'hFF, 1, 1'b0);
    check("t2_ovf_set", overflow_o, 1);
    check("t2_count_kept", count_o, 16);
    @(posedge clk); #1;
    rx_valid_i = 1'b1; rx_data_i = 8'hFE; clr_overflow_i = 1'b1;
    @(posedge clk); #1;
    rx_valid_i = 1'b0; clr_overflow_i = 1'b0;
    check("t2_set_wins", overflow_o, 1);
    @(posedge clk); #1;
    clr_overflow_i = 1'b1;
    @(posedge clk); #1;
    clr_overflow_i = 1'b0;
    check("t2_ovf_clr", overflow_o, 0);
    pop_n(DEPTH);
    tick(1);
    check("t2_empty", empty_o, 1);
    check("t2_rd_zero", rd_data_o, 0);
    pop_n(1);
    check("t2_pop_empty_count", count_o, 0);
    check("t2_pop_empty_ovf", overflow_o, 0);

    // 3: push and pop on a full FIFO
    for (int i = 0; i < DEPTH; i++) push_byte(DW'(8'h10 + i), 1, 1'b1);
    @(posedge clk); #1;
    rx_valid_i = 1'b1; rx_data_i = 8'h55; rd_en_i = 1'b1;
    exp_q.push_back(8'h55);
    @(posedge clk); #1;
    rx_valid_i = 1'b0; rd_en_i = 1'b0;
    check("t3_count", count_o, 16);
    check("t3_ovf", overflow_o, 0);
    check("t3_head", rd_data_o, 8'h11);
    pop_n(DEPTH);
    tick(1);
    check("t3_empty", empty_o, 1);

    // 4: fill-level interrupt
    threshold_i = 5'd4;
    for (int i = 0; i < 3; i++) push_byte(DW'(8'h40 + i), 1, 1'b1);
    tick(2);
    check("t4_level_3", level_irq_o, 0);
    push_byte(8'h43, 1, 1'b1);
    check("t4_level_lag", level_irq_o, 0);
    tick(1);
    check("t4_level_4", level_irq_o, 1);
    pop_n(1);
    tick(1);
    check("t4_level_drop", level_irq_o, 0);
    pop_n(3);
    threshold_i = '0;
    tick(1);

    // 5: flush with concurrent push keeps overflow
    for (int i = 0; i < DEPTH; i++) push_byte(DW'(8'h20 + i), 1, 1'b1);
    push_byte(8'hEE, 1, 1'b0);
    pop_n(11);
    check("t5_count5", count_o, 5);
    @(posedge clk); #1;
    flush_i = 1'b1; rx_valid_i = 1'b1; rx_data_i = 8'h77;
    @(posedge clk); #1;
    flush_i = 1'b0; rx_valid_i = 1'b0;
    exp_q.delete();
    check("t5_count", count_o, 0);
    check("t5_empty", empty_o, 1);
    check("t5_ovf_kept", overflow_o, 1);
    tick(3);
    check("t5_push_dropped", count_o, 0);
    @(posedge clk); #1; clr_overflow_i = 1'b1;
    @(posedge clk); #1; clr_overflow_i = 1'b0;

    // 6: idle timeout
    push_byte(8'h3C, 1, 1'b1);
`ifdef UART_RX_FIFO_TIMEOUT_EN
    tick(98);
    check("t6_tmo_early", timeout_irq_o, 0);
    tick(2);
    check("t6_tmo_set", timeout_irq_o, 1);
    tick(5);
    check("t6_tmo_hold", timeout_irq_o, 1);
    pop_n(1);
    check("t6_tmo_clr", timeout_irq_o, 0);
`else
    tick(150);
    check("t6_tmo_absent", timeout_irq_o, 0);
    pop_n(1);
`endif

    // reset in the middle of activity
    threshold_i = 5'd1;
    for (int i = 0; i < 3; i++) push_byte(DW'(8'h60 + i), 1, 1'b1);
    tick(2);
    check("rst_mid_level_pre", level_irq_o, 1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    exp_q.delete();
    check_reset_outputs("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    threshold_i = '0;
    tick(2);
    check("rst_mid_count_after", count_o, 0);
    check("rst_mid_empty_after", empty_o, 1);

    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
